// File: rtl/pipe_dmem_responder_if.sv
// Request/response bus between the pipeline MEM stage (master) and the data-memory responder (slave).
// One word request at a time; the response is a single-cycle pulse with no backpressure.
interface pipe_dmem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/pipe_dmem_responder.sv
// Word-addressed data memory for the MEM stage: accepts one request, waits LATENCY cycles
// (legal 0..15), then pulses rsp_valid once with load data and a misalignment/range error flag.
module pipe_dmem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic                    clk,
  input logic                    reset,
  pipe_dmem_responder_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_hold_q;
  logic                err_hold_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                in_resp;
  logic                addr_err;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   live_rdata;

  // Reset gates both handshake sides so a request coinciding with reset is never taken.
  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;
  assign in_resp       = (state_q == RESP) && !reset;

  assign addr_err   = (addr_q[1:0] != 2'b00) || ((addr_q >> 2) >= ADDR_W'(DEPTH));
  assign idx        = addr_q[IDX_W+1:2];
  assign live_rdata = (we_q || addr_err) ? '0 : mem[idx];

  // Live values during the pulse, held copies afterwards until the next response.
  assign bus.rsp_valid = in_resp;
  assign bus.rsp_rdata = in_resp ? live_rdata : rdata_hold_q;
  assign bus.rsp_err   = in_resp ? addr_err   : err_hold_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (LATENCY == 0) ? RESP : WAIT;
      WAIT: if (cnt_q == 4'd1) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the request latches carry no reset; they are only consumed after an accept reloads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      cnt_q   <= 4'(LATENCY);
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_hold_q <= '0;
      err_hold_q   <= 1'b0;
    end else if (in_resp) begin
      rdata_hold_q <= live_rdata;
      err_hold_q   <= addr_err;
    end
  end

  // NOTE: the array is deliberately not reset; a store aborted by reset in RESP is dropped.
  always_ff @(posedge clk) begin
    if (in_resp && we_q && !addr_err) mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_pipe_dmem_responder.sv
// Directed bench: one responder with LATENCY=2 and one with LATENCY=0, driven from a single
// linear sequence; inputs change and outputs are sampled just after the falling edge.
module tb_pipe_dmem_responder;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  // Index 0 drives the LATENCY=2 instance, index 1 the LATENCY=0 instance.
  logic        vld   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        rdy   [2];
  logic        rv    [2];
  logic        rerr  [2];
  logic [31:0] rd    [2];

  pipe_dmem_responder_if #(.DATA_W(32), .ADDR_W(32)) bus_l2 ();
  pipe_dmem_responder_if #(.DATA_W(32), .ADDR_W(32)) bus_l0 ();

  assign bus_l2.req_valid = vld[0];
  assign bus_l2.req_we    = we[0];
  assign bus_l2.req_addr  = addr[0];
  assign bus_l2.req_wdata = wdata[0];
  assign rdy[0]  = bus_l2.req_ready;
  assign rv[0]   = bus_l2.rsp_valid;
  assign rerr[0] = bus_l2.rsp_err;
  assign rd[0]   = bus_l2.rsp_rdata;

  assign bus_l0.req_valid = vld[1];
  assign bus_l0.req_we    = we[1];
  assign bus_l0.req_addr  = addr[1];
  assign bus_l0.req_wdata = wdata[1];
  assign rdy[1]  = bus_l0.req_ready;
  assign rv[1]   = bus_l0.rsp_valid;
  assign rerr[1] = bus_l0.rsp_err;
  assign rd[1]   = bus_l0.rsp_rdata;

  pipe_dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(2)) dut_l2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l2.slave)
  );

  pipe_dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(0)) dut_l0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Presents one request in an IDLE cycle and follows it to its response pulse.
  task automatic xact(input int d, input int lat, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    tick();
    vld[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    #1;
    check("idle_ready", 32'(rdy[d]), 32'd1);
    check("idle_no_rsp", 32'(rv[d]), 32'd0);
    for (int k = 0; k < lat; k++) begin
      tick();
      vld[d] = 1'b0;
      check("wait_no_rsp", 32'(rv[d]), 32'd0);
      check("wait_not_ready", 32'(rdy[d]), 32'd0);
    end
    tick();
    vld[d] = 1'b0;
    check("rsp_valid", 32'(rv[d]), 32'd1);
    check("rsp_rdata", rd[d], exp_rd);
    check("rsp_err", 32'(rerr[d]), 32'(exp_err));
    check("rsp_not_ready", 32'(rdy[d]), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
    end

    // Reset state
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check("reset_ready", 32'(rdy[d]), 32'd0);
      check("reset_rsp_valid", 32'(rv[d]), 32'd0);
      check("reset_rsp_rdata", rd[d], 32'd0);
      check("reset_rsp_err", 32'(rerr[d]), 32'd0);
    end
    reset = 1'b0;
    #1;
    check("release_ready_l2", 32'(rdy[0]), 32'd1);
    check("release_ready_l0", 32'(rdy[1]), 32'd1);

    // LATENCY=2: store then load back
    xact(0, 2, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xact(0, 2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Misaligned store must not touch memory; out-of-range load errors with zero data
    xact(0, 2, 1'b1, 32'h12, 32'h1234, 32'h0, 1'b1);
    xact(0, 2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    xact(0, 2, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
    tick();
    check("hold_rv_low", 32'(rv[0]), 32'd0);
    check("hold_err", 32'(rerr[0]), 32'd1);
    check("hold_rdata", rd[0], 32'h0);

    // Held request during WAIT of a prior load is taken only after the response
    tick();
    vld[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    #1;
    check("held_first_ready", 32'(rdy[0]), 32'd1);
    tick();
    we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h5;
    check("held_wait1_rv", 32'(rv[0]), 32'd0);
    check("held_wait1_ready", 32'(rdy[0]), 32'd0);
    tick();
    check("held_wait2_rv", 32'(rv[0]), 32'd0);
    tick();
    check("held_load_rv", 32'(rv[0]), 32'd1);
    check("held_load_rdata", rd[0], 32'hDEADBEEF);
    tick();
    check("held_idle_rv", 32'(rv[0]), 32'd0);
    check("held_idle_ready", 32'(rdy[0]), 32'd1);
    check("held_idle_rdata_hold", rd[0], 32'hDEADBEEF);
    check("held_idle_err_hold", 32'(rerr[0]), 32'd0);
    tick();
    vld[0] = 1'b0;
    check("held_store_wait1_rv", 32'(rv[0]), 32'd0);
    check("held_store_wait1_ready", 32'(rdy[0]), 32'd0);
    tick();
    check("held_store_wait2_rv", 32'(rv[0]), 32'd0);
    tick();
    check("held_store_rv", 32'(rv[0]), 32'd1);
    check("held_store_rdata", rd[0], 32'h0);
    check("held_store_err", 32'(rerr[0]), 32'd0);
    tick();
    check("held_store_after_rv", 32'(rv[0]), 32'd0);
    xact(0, 2, 1'b0, 32'h20, 32'h0, 32'h5, 1'b0);

    // Reset during WAIT of a store discards it
    xact(0, 2, 1'b1, 32'h30, 32'h0, 32'h0, 1'b0);
    tick();
    vld[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hAAAA5555;
    #1;
    check("abort_accept_ready", 32'(rdy[0]), 32'd1);
    tick();
    vld[0] = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_reset_ready", 32'(rdy[0]), 32'd0);
    check("abort_reset_rv", 32'(rv[0]), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("abort_release_ready", 32'(rdy[0]), 32'd1);
    check("abort_release_rv", 32'(rv[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_no_rsp", 32'(rv[0]), 32'd0);
      check("abort_idle_ready", 32'(rdy[0]), 32'd1);
    end
    xact(0, 2, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0);

    // Reset together with req_valid: nothing accepted
    tick();
    reset = 1'b1;
    vld[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    #1;
    check("rstvld_ready", 32'(rdy[0]), 32'd0);
    check("rstvld_rv", 32'(rv[0]), 32'd0);
    tick();
    reset = 1'b0;
    vld[0] = 1'b0;
    #1;
    check("rstvld_not_taken_ready", 32'(rdy[0]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rstvld_no_rsp", 32'(rv[0]), 32'd0);
      check("rstvld_still_idle", 32'(rdy[0]), 32'd1);
    end

    // LATENCY=0: response in the cycle after accept, back-to-back every 2 cycles
    xact(1, 0, 1'b1, 32'h10, 32'h0BADF00D, 32'h0, 1'b0);
    xact(1, 0, 1'b0, 32'h10, 32'h0, 32'h0BADF00D, 1'b0);
    xact(1, 0, 1'b0, 32'h10, 32'h0, 32'h0BADF00D, 1'b0);
    xact(1, 0, 1'b1, 32'h3FC, 32'h13579BDF, 32'h0, 1'b0);
    xact(1, 0, 1'b0, 32'h3FC, 32'h0, 32'h13579BDF, 1'b0);
    xact(1, 0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
    xact(1, 0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
    tick();
    check("l0_final_rv", 32'(rv[1]), 32'd0);
    check("l0_final_ready", 32'(rdy[1]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
